// File: rtl/phase_sequencer.sv
// phase_sequencer
// Divides the master clock into processor cycles of PHASES phases and
// emits one-master-cycle enable strobes at fixed phase positions.
// Run, stall and stop requests are acted on only at the processor-cycle
// boundary, so a cycle that has started always completes.
// Optional feature: define PHSEQ_CYCLE_COUNT_EN to add the 32-bit
// cycle_count output, which counts completed processor cycles.

module phase_sequencer #(
    parameter int PHASES  = 8,
    parameter int IMEM_PH = 1,
    parameter int REG_PH  = 0,
    parameter int DMEM_PH = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic       stall_req,
    output logic       stall_ack,
    output logic [3:0] phase,
    output logic       imem_en,
    output logic       regfile_en,
    output logic       dmem_en,
    output logic       proc_en,
    output logic       busy
`ifdef PHSEQ_CYCLE_COUNT_EN
    ,
    output logic [31:0] cycle_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Phase positions widened to 32 bits so that a position at or beyond
    // PHASES simply never matches the phase counter.
    localparam logic [3:0]  LAST_PH    = 4'(PHASES - 1);
    localparam logic [31:0] IMEM_MATCH = 32'(IMEM_PH);
    localparam logic [31:0] REG_MATCH  = 32'(REG_PH);
    localparam logic [31:0] DMEM_MATCH = 32'(DMEM_PH);
    localparam logic [31:0] PROC_MATCH = 32'(PHASES - 1);

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  phase_q;
    logic [3:0]  phase_d;
    logic [31:0] phase_wide;

    assign phase_wide = {28'd0, phase_q};

    // State and phase registers; reset drops straight back to IDLE, phase 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            phase_q <= 4'd0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    // Next-state logic: run/stall are only looked at on the last phase.
    always_comb begin
        state_d = state_q;
        phase_d = 4'd0;
        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (phase_q == LAST_PH) begin
                    if (!run) begin
                        state_d = IDLE;
                    end else if (stall_req) begin
                        state_d = HOLD;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            HOLD: begin
                if (!run) begin
                    state_d = IDLE;
                end else if (!stall_req) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore outputs decoded only from the registered state and phase.
    always_comb begin
        phase      = phase_q;
        imem_en    = 1'b0;
        regfile_en = 1'b0;
        dmem_en    = 1'b0;
        proc_en    = 1'b0;
        busy       = (state_q != IDLE);
        stall_ack  = (state_q == HOLD);
        if (state_q == RUN) begin
            imem_en    = (phase_wide == IMEM_MATCH);
            regfile_en = (phase_wide == REG_MATCH);
            dmem_en    = (phase_wide == DMEM_MATCH);
            proc_en    = (phase_wide == PROC_MATCH);
        end
    end

`ifdef PHSEQ_CYCLE_COUNT_EN
    logic [31:0] count_q;

    // Completed-cycle counter: one step per proc_en strobe, wrapping freely.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= 32'd0;
        end else if (proc_en) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign cycle_count = count_q;
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer
// Drives two sequencer instances (default parameters, and a 2-phase one
// with coinciding enables plus an out-of-range register phase) from the
// same run/stall/reset inputs and compares every output after each edge
// against a cycle-position model. With PHSEQ_CYCLE_COUNT_EN defined the
// cycle counters are also checked, including a forced wrap.

module tb_phase_sequencer;

    logic       clock;
    logic       reset;
    logic       run;
    logic       stall_req;

    logic       stall_ack_a, stall_ack_b;
    logic [3:0] phase_a, phase_b;
    logic       imem_en_a, imem_en_b;
    logic       regfile_en_a, regfile_en_b;
    logic       dmem_en_a, dmem_en_b;
    logic       proc_en_a, proc_en_b;
    logic       busy_a, busy_b;
`ifdef PHSEQ_CYCLE_COUNT_EN
    logic [31:0] cycle_count_a, cycle_count_b;
`endif

    int vectors;
    int miscompares;

    // Model: position inside the current processor cycle (-1 when no
    // cycle is in progress), a holding flag and a completed-cycle tally.
    int          m_pos   [2];
    bit          m_hold  [2];
    logic [31:0] m_count [2];
    int          m_phases[2];
    int          m_imem  [2];
    int          m_reg   [2];
    int          m_dmem  [2];

    phase_sequencer dut_a (
        .clock      (clock),
        .reset      (reset),
        .run        (run),
        .stall_req  (stall_req),
        .stall_ack  (stall_ack_a),
        .phase      (phase_a),
        .imem_en    (imem_en_a),
        .regfile_en (regfile_en_a),
        .dmem_en    (dmem_en_a),
        .proc_en    (proc_en_a),
        .busy       (busy_a)
`ifdef PHSEQ_CYCLE_COUNT_EN
        ,
        .cycle_count(cycle_count_a)
`endif
    );

    phase_sequencer #(
        .PHASES (2),
        .IMEM_PH(1),
        .REG_PH (2),
        .DMEM_PH(1)
    ) dut_b (
        .clock      (clock),
        .reset      (reset),
        .run        (run),
        .stall_req  (stall_req),
        .stall_ack  (stall_ack_b),
        .phase      (phase_b),
        .imem_en    (imem_en_b),
        .regfile_en (regfile_en_b),
        .dmem_en    (dmem_en_b),
        .proc_en    (proc_en_b),
        .busy       (busy_b)
`ifdef PHSEQ_CYCLE_COUNT_EN
        ,
        .cycle_count(cycle_count_b)
`endif
    );

    // Free-running master clock, 10 time units per period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic cmp(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            m_pos[i]   = -1;
            m_hold[i]  = 1'b0;
            m_count[i] = 32'd0;
        end
    endtask

    // One master edge of the model for instance i.
    task automatic modelEdge(input int i, input bit r, input bit s);
        if (m_pos[i] >= 0) begin
            if (m_pos[i] == m_phases[i] - 1) begin
                m_count[i] = m_count[i] + 32'd1;
                if (!r) begin
                    m_pos[i] = -1;
                end else if (s) begin
                    m_pos[i]  = -1;
                    m_hold[i] = 1'b1;
                end else begin
                    m_pos[i] = 0;
                end
            end else begin
                m_pos[i] = m_pos[i] + 1;
            end
        end else if (m_hold[i]) begin
            if (!r) begin
                m_hold[i] = 1'b0;
            end else if (!s) begin
                m_hold[i] = 1'b0;
                m_pos[i]  = 0;
            end
        end else if (r) begin
            m_pos[i] = 0;
        end
    endtask

    task automatic checkOutput(input string tag);
        int pa;
        int pb;
        pa = (m_pos[0] >= 0) ? m_pos[0] : 0;
        pb = (m_pos[1] >= 0) ? m_pos[1] : 0;
        cmp({tag, "/a.phase"},     32'(phase_a),      32'(pa));
        cmp({tag, "/a.imem"},      32'(imem_en_a),    32'(m_pos[0] == m_imem[0]));
        cmp({tag, "/a.regfile"},   32'(regfile_en_a), 32'(m_pos[0] == m_reg[0]));
        cmp({tag, "/a.dmem"},      32'(dmem_en_a),    32'(m_pos[0] == m_dmem[0]));
        cmp({tag, "/a.proc"},      32'(proc_en_a),    32'(m_pos[0] == m_phases[0] - 1));
        cmp({tag, "/a.stall_ack"}, 32'(stall_ack_a),  32'(m_hold[0]));
        cmp({tag, "/a.busy"},      32'(busy_a),       32'((m_pos[0] >= 0) || m_hold[0]));
        cmp({tag, "/b.phase"},     32'(phase_b),      32'(pb));
        cmp({tag, "/b.imem"},      32'(imem_en_b),    32'(m_pos[1] == m_imem[1]));
        cmp({tag, "/b.regfile"},   32'(regfile_en_b), 32'(m_pos[1] == m_reg[1]));
        cmp({tag, "/b.dmem"},      32'(dmem_en_b),    32'(m_pos[1] == m_dmem[1]));
        cmp({tag, "/b.proc"},      32'(proc_en_b),    32'(m_pos[1] == m_phases[1] - 1));
        cmp({tag, "/b.stall_ack"}, 32'(stall_ack_b),  32'(m_hold[1]));
        cmp({tag, "/b.busy"},      32'(busy_b),       32'((m_pos[1] >= 0) || m_hold[1]));
`ifdef PHSEQ_CYCLE_COUNT_EN
        cmp({tag, "/a.count"},     cycle_count_a,     m_count[0]);
        cmp({tag, "/b.count"},     cycle_count_b,     m_count[1]);
`endif
    endtask

    // Set inputs between edges, take one rising edge, check 1 unit later.
    task automatic applyStimulus(input bit r, input bit s, input string tag);
        run       = r;
        stall_req = s;
        @(posedge clock);
        if (!reset) begin
            modelReset();
        end else begin
            modelEdge(0, r, s);
            modelEdge(1, r, s);
        end
        #1;
        checkOutput(tag);
    endtask

    // Reset pulse wholly between two edges; outputs must clear at once.
    task automatic pulseReset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        modelReset();
        checkOutput({tag, "/during"});
        #2;
        reset = 1'b1;
        #1;
        checkOutput({tag, "/after"});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_phases = '{8, 2};
        m_imem   = '{1, 1};
        m_reg    = '{0, 2};
        m_dmem   = '{5, 1};
        modelReset();

        reset     = 1'b0;
        run       = 1'b0;
        stall_req = 1'b0;
        #2;
        checkOutput("reset_state");
        @(posedge clock);
        #1;
        reset = 1'b1;

        $display("[TB] idle with run low");
        applyStimulus(1'b0, 1'b0, "idle");
        applyStimulus(1'b0, 1'b0, "idle");

        $display("[TB] twenty edges with run held high");
        for (int k = 0; k < 20; k++) applyStimulus(1'b1, 1'b0, "run20");
        cmp("run20/a.final_phase", 32'(phase_a), 32'd3);
`ifdef PHSEQ_CYCLE_COUNT_EN
        cmp("run20/a.final_count", cycle_count_a, 32'd2);
`endif

        $display("[TB] stall raised mid-cycle");
        for (int k = 0; k < 7; k++) applyStimulus(1'b1, 1'b1, "stall");
        cmp("stall/a.in_hold", 32'(stall_ack_a), 32'd1);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, "unstall");

        $display("[TB] run dropped and stall raised at phase 6");
        for (int k = 0; k < 16 && m_pos[0] != 6; k++) applyStimulus(1'b1, 1'b0, "to_ph6");
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b1, "stop");
        cmp("stop/a.busy", 32'(busy_a), 32'd0);

        $display("[TB] reset pulse at phase 4");
        for (int k = 0; k < 16 && m_pos[0] != 4; k++) applyStimulus(1'b1, 1'b0, "to_ph4");
        pulseReset("mid_reset");
        applyStimulus(1'b0, 1'b0, "post_reset");
        applyStimulus(1'b0, 1'b0, "post_reset");
        applyStimulus(1'b1, 1'b0, "restart");
        cmp("restart/a.busy", 32'(busy_a), 32'd1);

        $display("[TB] randomized run/stall/reset traffic");
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 99) < 2) begin
                pulseReset("rand_reset");
            end
            applyStimulus($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 30, "random");
        end

`ifdef PHSEQ_CYCLE_COUNT_EN
        $display("[TB] counter wrap on 2-phase instance");
        applyStimulus(1'b1, 1'b0, "pre_wrap");
        force dut_b.count_q = 32'hFFFF_FFFF;
        #1;
        release dut_b.count_q;
        m_count[1] = 32'hFFFF_FFFF;
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b0, "wrap");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
